// File: rtl/ball_motion.sv
// Ball kinematics for the pong playfield: prescaled tick, serve hold,
// sticky flip requests and radius-clamped stepping on a 64x64 field.
module ball_motion #(
  parameter int TICK_DIV    = 100000,
  parameter int SERVE_TICKS = 32,
  parameter int CENTER_X    = 32,
  parameter int CENTER_Y    = 32
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic [4:0] change_in_direction,
  input  logic [4:0] ball_radius,
  output logic [5:0] ball_x,
  output logic [5:0] ball_y,
  output logic       dir_x,
  output logic       dir_y,
  output logic       in_play,
  output logic       tick
);

  localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam int SW = $clog2(SERVE_TICKS + 1);

  localparam logic [PW-1:0] PMAX     = PW'(TICK_DIV - 1);
  localparam logic [SW-1:0] CNT_INIT = SW'(SERVE_TICKS);
  localparam logic [5:0]    CX       = 6'(CENTER_X);
  localparam logic [5:0]    CY       = 6'(CENTER_Y);

  typedef enum logic {
    SERVE = 1'b0,
    MOVE  = 1'b1
  } state_e;

  state_e        state_q;
  logic [PW-1:0] presc_q;
  logic [SW-1:0] cnt_q;
  logic [1:0]    pend_q;
  logic [5:0]    x_q, y_q;
  logic          dx_q, dy_q;
  logic          play_q, tick_q;

  logic       wrap;
  logic       serve_req;
  logic [1:0] pend_now;
  logic [2:0] step;
  logic       dx_d, dy_d;
  logic [5:0] x_d, y_d;

  // Eight signed bits: 63 + 4 must not wrap before the clamp sees it.
  function automatic logic [5:0] step_axis(
    input logic [5:0] pos,
    input logic       dir,
    input logic [2:0] stp,
    input logic [4:0] r
  );
    logic signed [7:0] v, lo, hi, d;
    d  = $signed({5'b00000, stp});
    v  = $signed({2'b00, pos}) + (dir ? d : -d);
    lo = $signed({3'b000, r});
    hi = 8'sd63 - lo;
    if (lo > hi || v < lo) return 6'(lo);
    else if (v > hi)       return 6'(hi);
    else                   return 6'(v);
  endfunction

  assign wrap      = enable && (presc_q == PMAX);
  assign serve_req = change_in_direction[2];
  assign pend_now  = pend_q | change_in_direction[1:0];
  assign step      = {1'b0, change_in_direction[4:3]} + 3'd1;
  assign dx_d      = dx_q ^ pend_now[0];
  assign dy_d      = dy_q ^ pend_now[1];
  assign x_d       = step_axis(x_q, dx_d, step, ball_radius);
  assign y_d       = step_axis(y_q, dy_d, step, ball_radius);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= SERVE;
      presc_q <= '0;
      cnt_q   <= CNT_INIT;
      pend_q  <= '0;
      x_q     <= CX;
      y_q     <= CY;
      dx_q    <= 1'b1;
      dy_q    <= 1'b1;
      play_q  <= 1'b0;
      tick_q  <= 1'b0;
    end else begin
      if (enable) presc_q <= wrap ? '0 : presc_q + PW'(1);
      tick_q <= wrap && !serve_req;
      if (serve_req) begin
        state_q <= SERVE;
        cnt_q   <= CNT_INIT;
        pend_q  <= '0;
        x_q     <= CX;
        y_q     <= CY;
        dx_q    <= ~dx_q;
        play_q  <= 1'b0;
      end else if (wrap) begin
        pend_q <= '0;
        unique case (state_q)
          SERVE: begin
            if (cnt_q == SW'(1)) begin
              state_q <= MOVE;
              play_q  <= 1'b1;
            end else begin
              cnt_q <= cnt_q - SW'(1);
            end
          end
          MOVE: begin
            dx_q <= dx_d;
            dy_q <= dy_d;
            x_q  <= x_d;
            y_q  <= y_d;
          end
        endcase
      end else begin
        pend_q <= pend_now;
      end
    end
  end

  assign ball_x  = x_q;
  assign ball_y  = y_q;
  assign dir_x   = dx_q;
  assign dir_y   = dy_q;
  assign in_play = play_q;
  assign tick    = tick_q;

endmodule

// File: tb/tb_ball_motion.sv
// Scoreboard bench for ball_motion: expected per-tick results are queued
// as stimulus is driven and compared when the DUT pulses tick.
module tb_ball_motion;

  logic       clk;
  logic       rst;
  logic       enable;
  logic [4:0] cdir;
  logic [4:0] radius;
  logic [1:0] spd;
  logic [5:0] ball_x, ball_y;
  logic       dir_x, dir_y, in_play, tick;

  typedef struct {
    int x;
    int y;
    int dx;
    int dy;
    int play;
  } exp_t;

  exp_t sb[$];
  int   n_chk = 0;
  int   n_err = 0;

  ball_motion #(
    .TICK_DIV   (4),
    .SERVE_TICKS(2),
    .CENTER_X   (32),
    .CENTER_Y   (32)
  ) dut (
    .clk                (clk),
    .rst                (rst),
    .enable             (enable),
    .change_in_direction(cdir),
    .ball_radius        (radius),
    .ball_x             (ball_x),
    .ball_y             (ball_y),
    .dir_x              (dir_x),
    .dir_y              (dir_y),
    .in_play            (in_play),
    .tick               (tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int want);
    n_chk++;
    if (got != want) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, want);
    end
  endtask

  always @(posedge clk) begin
    #1;
    if (tick === 1'b1) begin
      if (sb.size() == 0) begin
        chk("tick_unexpected", 1, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("tk_x", ball_x, e.x);
        chk("tk_y", ball_y, e.y);
        chk("tk_dx", dir_x, e.dx);
        chk("tk_dy", dir_y, e.dy);
        chk("tk_play", in_play, e.play);
      end
    end
  end

  task automatic push(input int x, input int y, input int dx,
                      input int dy, input int p);
    exp_t e;
    e = '{x, y, dx, dy, p};
    sb.push_back(e);
  endtask

  // Returns on the negedge of the cycle in which tick is high.
  task automatic exp_tick(input int x, input int y, input int dx,
                          input int dy, input int p);
    bit done;
    push(x, y, dx, dy, p);
    done = 0;
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge clk);
      cdir = {spd, 3'b000};
      if (sb.size() == 0) done = 1;
    end
    if (!done) begin
      chk("tick_timeout", 0, 1);
      sb.delete();
    end
  endtask

  task automatic do_reset();
    rst    = 1'b0;
    spd    = 2'd0;
    cdir   = 5'd0;
    radius = 5'd2;
    enable = 1'b1;
    sb.delete();
    repeat (3) @(negedge clk);
    chk("rst_x", ball_x, 32);
    chk("rst_y", ball_y, 32);
    chk("rst_dx", dir_x, 1);
    chk("rst_dy", dir_y, 1);
    chk("rst_play", in_play, 0);
    chk("rst_tick", tick, 0);
    push(32, 32, 1, 1, 0);
    push(32, 32, 1, 1, 1);
    push(33, 33, 1, 1, 1);
    rst = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      @(posedge clk);
      #1;
      chk("tick_edge", tick, (i % 4 == 0) ? 1 : 0);
    end
    @(negedge clk);
    chk("rst_sb_empty", sb.size(), 0);
  endtask

  initial begin
    rst    = 1'b0;
    enable = 1'b1;
    cdir   = 5'd0;
    spd    = 2'd0;
    radius = 5'd2;

    do_reset();
    exp_tick(34, 34, 1, 1, 1);

    // single flip_x mid-interval
    @(negedge clk);
    cdir = 5'b00001;
    exp_tick(33, 35, 0, 1, 1);

    // two flip_x pulses, one reversal
    cdir = 5'b00001;
    @(negedge clk);
    cdir = 5'b00000;
    @(negedge clk);
    cdir = 5'b00001;
    exp_tick(34, 36, 1, 1, 1);

    // flip_y on the wrap cycle itself
    repeat (3) @(negedge clk);
    cdir = 5'b00010;
    exp_tick(35, 35, 1, 0, 1);

    // speed and clamping
    radius = 5'd4;
    spd    = 2'd3;
    cdir   = {spd, 3'b010};
    exp_tick(39, 39, 1, 1, 1);
    exp_tick(43, 43, 1, 1, 1);
    exp_tick(47, 47, 1, 1, 1);
    exp_tick(51, 51, 1, 1, 1);
    exp_tick(55, 55, 1, 1, 1);
    spd  = 2'd2;
    cdir = {spd, 3'b000};
    exp_tick(58, 58, 1, 1, 1);
    spd  = 2'd3;
    cdir = {spd, 3'b000};
    exp_tick(59, 59, 1, 1, 1);
    exp_tick(59, 59, 1, 1, 1);
    radius = 5'd31;
    exp_tick(32, 32, 1, 1, 1);
    cdir = {spd, 3'b011};
    exp_tick(31, 31, 0, 0, 1);
    radius = 5'd2;
    spd    = 2'd0;
    cdir   = 5'd0;

    // pause with flip_y inside
    repeat (2) @(negedge clk);
    enable = 1'b0;
    for (int i = 0; i < 10; i++) begin
      cdir = (i == 4) ? 5'b00010 : 5'b00000;
      @(posedge clk);
      #1;
      chk("pause_x", ball_x, 31);
      chk("pause_y", ball_y, 31);
      chk("pause_dy", dir_y, 0);
      chk("pause_tick", tick, 0);
      @(negedge clk);
    end
    cdir   = 5'd0;
    enable = 1'b1;
    exp_tick(30, 32, 0, 1, 1);

    // serve coincident with tick, flip_y pending
    cdir = 5'b00010;
    @(negedge clk);
    cdir = 5'b00000;
    repeat (2) @(negedge clk);
    cdir = 5'b00100;
    @(posedge clk);
    #1;
    chk("srv_x", ball_x, 32);
    chk("srv_y", ball_y, 32);
    chk("srv_play", in_play, 0);
    chk("srv_dx", dir_x, 1);
    chk("srv_dy", dir_y, 1);
    @(negedge clk);
    cdir = 5'b00000;
    exp_tick(32, 32, 1, 1, 0);
    exp_tick(32, 32, 1, 1, 1);
    exp_tick(33, 33, 1, 1, 1);

    // serve held three cycles re-arms and toggles each cycle
    cdir = 5'b00100;
    repeat (3) @(negedge clk);
    chk("hold_x", ball_x, 32);
    chk("hold_dx", dir_x, 0);
    chk("hold_play", in_play, 0);
    cdir = 5'b00000;
    exp_tick(32, 32, 0, 1, 0);
    exp_tick(32, 32, 0, 1, 1);
    exp_tick(31, 33, 0, 1, 1);

    // reset mid-interval with flip_x pending
    @(negedge clk);
    cdir = 5'b00001;
    @(negedge clk);
    cdir = 5'b00000;
    do_reset();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_err);
    $finish;
  end

endmodule
